// File: rtl/lutram_bist_pkg.sv
// Shared types, widths and the data-pattern function for the LUTRAM BIST sequencer.
package lutram_bist_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned ERR_W  = 16;
  localparam logic [DATA_W-1:0] SEED_DEFAULT = 10'h2A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // True pattern for an address already zero-extended to the data width.
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] addr,
                                                input logic [DATA_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/lutram_bist_cmp.sv
// Registered read-compare stage: saturating error counter and optional first-fail capture.
// First-fail capture is built only when LUTRAM_BIST_FAIL_CAPTURE_EN is defined.
module lutram_bist_cmp
  import lutram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_valid,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_exp,
  input  logic [DATA_W-1:0] cap_act,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_zero_nxt_c,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] act_q;
  logic              mismatch_c;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      act_q <= '0;
    end else begin
      vld_q <= cap_valid;
      exp_q <= cap_exp;
      act_q <= cap_act;
    end
  end

  assign mismatch_c = vld_q && (exp_q != act_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= '0;
    end else if (mismatch_c && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // Lets the parent register pass on the same edge that retires the last compare.
  assign err_zero_nxt_c = (err_cnt == '0) && !mismatch_c;

`ifdef LUTRAM_BIST_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] addr_q;
  logic              captured_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr_q     <= '0;
      captured_q <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      addr_q <= cap_addr;
      if (mismatch_c && !captured_q) begin
        captured_q <= 1'b1;
        fail_addr  <= addr_q;
        fail_data  <= act_q;
      end
    end
  end
`else
  logic unused_cap_addr;
  assign unused_cap_addr = ^cap_addr;
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: rtl/lutram_bist.sv
// Write/read-back/compare sequencer for the LUTRAM stress array, true then inverted pattern.
// Optional first-fail capture: define LUTRAM_BIST_FAIL_CAPTURE_EN.
module lutram_bist
  import lutram_bist_pkg::*;
#(
  parameter int unsigned       LUTRAM16X10 = 10,
  parameter int unsigned       ADDR_W      = $clog2(16 * LUTRAM16X10),
  parameter logic [DATA_W-1:0] SEED        = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdat,
  input  logic [DATA_W-1:0] mem_rdat
);

  localparam int unsigned       DEPTH     = 16 * LUTRAM16X10;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic              phase;
  logic              start_acc_c;
  logic              err_zero_nxt_c;
  logic [ADDR_W-1:0] addr_nxt_c;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a, input logic ph);
    logic [DATA_W-1:0] p;
    p = pattern(DATA_W'(a), SEED);
    return ph ? ~p : p;
  endfunction

  assign start_acc_c = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign addr_nxt_c  = mem_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_wdat <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_WR;
            phase    <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            mem_addr <= '0;
            mem_we   <= 1'b1;
            mem_wdat <= word_of('0, 1'b0);
          end
        end
        ST_WR: begin
          if (mem_addr == ADDR_LAST) begin
            state    <= ST_RD;
            mem_addr <= '0;
            mem_we   <= 1'b0;
          end else begin
            mem_addr <= addr_nxt_c;
            mem_wdat <= word_of(addr_nxt_c, phase);
          end
        end
        ST_RD: begin
          if (mem_addr == ADDR_LAST) begin
            state <= ST_DRAIN;
          end else begin
            mem_addr <= addr_nxt_c;
          end
        end
        ST_DRAIN: begin
          if (!phase) begin
            state    <= ST_WR;
            phase    <= 1'b1;
            mem_addr <= '0;
            mem_we   <= 1'b1;
            mem_wdat <= word_of('0, 1'b1);
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_zero_nxt_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lutram_bist_cmp #(
    .ADDR_W(ADDR_W)
  ) u_cmp (
    .clk           (clk),
    .rst           (rst),
    .clr           (start_acc_c),
    .cap_valid     (state == ST_RD),
    .cap_addr      (mem_addr),
    .cap_exp       (word_of(mem_addr, phase)),
    .cap_act       (mem_rdat),
    .err_cnt       (err_cnt),
    .err_zero_nxt_c(err_zero_nxt_c),
    .fail_addr     (fail_addr),
    .fail_data     (fail_data)
  );

endmodule

// File: tb/tb_lutram_bist.sv
// Bench for lutram_bist: full-size array (N=160) with optional stuck-at fault, plus a one-slice instance.
module tb_lutram_bist;

  localparam int N   = 160;
  localparam int N_S = 16;

`ifdef LUTRAM_BIST_FAIL_CAPTURE_EN
  localparam logic [7:0] STUCK_FA = 8'd40;
  localparam logic [9:0] STUCK_FD = 10'h285;
`else
  localparam logic [7:0] STUCK_FA = 8'd0;
  localparam logic [9:0] STUCK_FD = 10'd0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [7:0]  fail_addr;
  logic [9:0]  fail_data;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [9:0]  mem_wdat;
  logic [9:0]  mem_rdat;

  logic        start_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] err_cnt_s;
  logic [3:0]  fail_addr_s;
  logic [9:0]  fail_data_s;
  logic [3:0]  mem_addr_s;
  logic        mem_we_s;
  logic [9:0]  mem_wdat_s;
  logic [9:0]  mem_rdat_s;

  int tests = 0;
  int fails = 0;
  bit stuck = 1'b0;

  lutram_bist #(.LUTRAM16X10(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  lutram_bist #(.LUTRAM16X10(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_cnt_s), .fail_addr(fail_addr_s), .fail_data(fail_data_s),
    .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdat(mem_wdat_s), .mem_rdat(mem_rdat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array models; slice 2 (addr 32..47) bit 3 optionally stuck at 0.
  logic [9:0] mem   [N];
  logic [9:0] mem_s [N_S];
  logic [9:0] rd_raw;

  always @(posedge clk) begin
    if (mem_we && (int'(mem_addr) < N)) mem[mem_addr] <= mem_wdat;
    if (mem_we_s) mem_s[mem_addr_s] <= mem_wdat_s;
  end

  assign rd_raw     = (int'(mem_addr) < N) ? mem[mem_addr] : 10'd0;
  assign mem_rdat   = (stuck && mem_addr >= 8'd32 && mem_addr <= 8'd47) ? (rd_raw & ~10'h008) : rd_raw;
  assign mem_rdat_s = mem_s[mem_addr_s];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: every write must follow the independent pattern model.
  int         wr_idx = 0;
  int         max_s  = 0;
  logic [7:0] exp_a;
  logic [9:0] exp_w;

  always @(negedge clk) begin
    if (!busy) wr_idx = 0;
    if (mem_we) begin
      exp_a = 8'(wr_idx % N);
      exp_w = {2'b00, exp_a} ^ 10'h2A5;
      if (wr_idx >= N) exp_w = ~exp_w;
      check("wr_busy", 32'(busy), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'(exp_a));
      check("wr_data", 32'(mem_wdat), 32'(exp_w));
      wr_idx++;
    end
    if (int'(mem_addr) >= N) check("addr_range", 32'(mem_addr), 32'(N - 1));
    if (!rst && int'(mem_addr_s) > max_s) max_s = int'(mem_addr_s);
  end

  typedef struct {
    string      name;
    bit         stuck;
    int         restart_at;
    int         exp_lat;
    logic [15:0] exp_err;
    bit         exp_pass;
    logic [7:0] exp_fa;
    logic [9:0] exp_fd;
  } vec_t;

  typedef struct {
    int          lat;
    logic [15:0] err;
    bit          pas;
    logic [7:0]  fa;
    logic [9:0]  fd;
  } exp_t;

  vec_t vecs[4];
  exp_t sb_q[$];

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int          cyc;
    logic [15:0] err_hold;
    stuck = v.stuck;
    sb_q.push_back('{v.exp_lat, v.exp_err, v.exp_pass, v.exp_fa, v.exp_fd});
    @(negedge clk); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    check({v.name, "/first_busy"}, 32'(busy), 32'd1);
    check({v.name, "/first_done"}, 32'(done), 32'd0);
    check({v.name, "/first_err"}, 32'(err_cnt), 32'd0);
    check({v.name, "/first_fa"}, 32'(fail_addr), 32'd0);
    check({v.name, "/first_we"}, 32'(mem_we), 32'd1);
    check({v.name, "/first_addr"}, 32'(mem_addr), 32'd0);
    check({v.name, "/first_wdat"}, 32'(mem_wdat), 32'h2A5);
    while (!done && cyc < 2000) begin
      start = (cyc == v.restart_at);
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check({v.name, "/latency"}, 32'(cyc), 32'(e.lat));
    check({v.name, "/err_cnt"}, 32'(err_cnt), 32'(e.err));
    check({v.name, "/pass"}, 32'(pass), 32'(e.pas));
    check({v.name, "/busy_end"}, 32'(busy), 32'd0);
    check({v.name, "/fail_addr"}, 32'(fail_addr), 32'(e.fa));
    check({v.name, "/fail_data"}, 32'(fail_data), 32'(e.fd));
    err_hold = err_cnt;
    repeat (5) @(negedge clk);
    check({v.name, "/done_hold"}, 32'(done), 32'd1);
    check({v.name, "/err_stable"}, 32'(err_cnt), 32'(err_hold));
  endtask

  initial begin
    int cyc;
    vecs[0] = '{"clean",         1'b0,  -1, 643, 16'd0,  1'b1, 8'd0,     10'd0};
    vecs[1] = '{"stuck",         1'b1,  -1, 643, 16'd16, 1'b0, STUCK_FA, STUCK_FD};
    vecs[2] = '{"clean_restart", 1'b0, 100, 643, 16'd0,  1'b1, 8'd0,     10'd0};
    vecs[3] = '{"stuck_restart", 1'b1, 500, 643, 16'd16, 1'b0, STUCK_FA, STUCK_FD};

    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/pass", 32'(pass), 32'd0);
    check("rst/err", 32'(err_cnt), 32'd0);
    check("rst/we", 32'(mem_we), 32'd0);
    check("rst/addr", 32'(mem_addr), 32'd0);
    check("rst/wdat", 32'(mem_wdat), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Restart from DONE with prior errors: counter clears and the run repeats.
    run_vec('{"done_restart", 1'b1, -1, 643, 16'd16, 1'b0, STUCK_FA, STUCK_FD});

    // Abort a faulty run mid-sweep, then a clean run.
    stuck = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    while (cyc < 300) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check("abort/err_before", 32'(err_cnt), 32'd8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/pass", 32'(pass), 32'd0);
    check("abort/err", 32'(err_cnt), 32'd0);
    check("abort/fa", 32'(fail_addr), 32'd0);
    check("abort/fd", 32'(fail_data), 32'd0);
    check("abort/addr", 32'(mem_addr), 32'd0);
    check("abort/we", 32'(mem_we), 32'd0);
    check("abort/wdat", 32'(mem_wdat), 32'd0);
    run_vec('{"after_abort", 1'b0, -1, 643, 16'd0, 1'b1, 8'd0, 10'd0});

    // Single-slice instance.
    max_s = 0;
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start_s = 1'b0;
    while (!done_s && cyc < 500) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check("small/latency", 32'(cyc), 32'd67);
    check("small/pass", 32'(pass_s), 32'd1);
    check("small/err", 32'(err_cnt_s), 32'd0);
    check("small/max_addr", 32'(max_s), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lutram_bist.md
# lutram_bist

Self-checking stimulus sequencer that sits directly upstream of the LUTRAM stress-test array and closes the loop on its read port. On `start` it writes a deterministic pattern to every word, reads every word back, and compares the result. It then repeats the sweep with the pattern inverted. It reports done/pass and an error count, so the stress build can be judged on hardware from a couple of pins.

## Interface
- `LUTRAM16X10`, default 10: number of 16x10 LUTRAM slices in the target array; depth N = 16*LUTRAM16X10; legal range 1..64.
- `ADDR_W`, default $clog2(16*LUTRAM16X10): address width; derived, not overridden.
- `SEED`, default 10'h2A5: XOR seed for the data pattern.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is entered.
- `done`  out  1  high in DONE; held until the next accepted `start` or `rst`.
- `pass`  out  1  `done` and `err_cnt`==0.
- `err_cnt`  out  16  count of mismatching words; saturates at 16'hFFFF.
- `fail_addr`  out  ADDR_W  first failing address (see Configuration).
- `fail_data`  out  10  read data of the first failure (see Configuration).
- `mem_addr`  out  ADDR_W  to array `addr`; registered.
- `mem_we`  out  1  to array `we`; registered.
- `mem_wdat`  out  10  to array `wdat`; registered.
- `mem_rdat`  in  10  from array `rdat`; combinational function of `mem_addr`.

## Operation
- States: IDLE, WR, RD, DRAIN, DONE. A 1-bit `phase` register selects pattern (0 = true, 1 = inverted).
- Pattern: P(a) = zero-extend(a to 10 b) ^ SEED; word = phase ? ~P(a) : P(a).
- IDLE/DONE + `start` -> WR. `phase`=0, addr=0, `err_cnt`=0; fail capture cleared.
- WR: `mem_we`=1, `mem_wdat`=word(addr). addr increments each cycle. After addr N-1 -> RD with addr=0.
- RD: `mem_we`=0. Each cycle the expected word and `mem_rdat` are registered into a compare stage. After addr N-1 -> DRAIN.
- Compare stage: one cycle after capture, a mismatch increments `err_cnt` (saturating).
- DRAIN: lasts one cycle and retires the last compare. Then, if `phase`==0, set `phase`=1 and go to WR with addr=0; otherwise go to DONE.
- `start` in WR/RD/DRAIN is ignored.
- `mem_we` is never high outside WR.
- `mem_addr` never exceeds N-1. Addresses N..2^ADDR_W-1 are never touched.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_addr`=0, `fail_data`=0, `mem_addr`=0, `mem_we`=0, `mem_wdat`=0, `phase`=0.
- `rst` mid-sweep aborts on that edge and forces all reset values. No partial result survives.
- Latency from accepted `start` to `done`: 2*(2N+1)+1 cycles. This is 643 cycles at N=160, and 67 cycles at LUTRAM16X10=1.
- Read compare latency: 1 cycle after the RD cycle presenting the address. A compare retiring on the same edge as the RD->DRAIN transition is counted.
- `err_cnt` is stable once `done` rises.

## Configuration
- `LUTRAM_BIST_FAIL_CAPTURE_EN` defined: on the first mismatch after `start`, `fail_addr` and `fail_data` latch the compared address and the actual read data. They hold until the next `start` or `rst`.
- Not defined: `fail_addr` and `fail_data` are tied to 0, and no capture registers are built.

## Structure
- Shared package `lutram_bist_pkg`: state enum, SEED default, `ERR_W`=16, and the pattern function P().
- One natural sub-module, `lutram_bist_cmp`: a registered compare stage with the saturating error counter and optional first-fail capture.

## Test plan
- Healthy array (LUTRAM16X10=10), pulse `start` -> `done` at cycle 643, `pass`=1, `err_cnt`=0. The first WR cycle shows `mem_addr`=0, `mem_wdat`=10'h2A5.
- Bit 3 of slice 2 forced stuck-at-0 -> `err_cnt`=16 (the words in addr 32..47 where the expected bit 3 is 1, summed over both phases), `pass`=0. With the macro, `fail_addr` = first such address.
- `start` re-pulsed at cycle 100 -> ignored; `done` still at 643 and results unchanged.
- `rst` at cycle 300, then `start` -> all outputs at reset values for one cycle, then a full clean run with `pass`=1.
- LUTRAM16X10=1 -> `mem_addr` sweeps 0..15 only, and `done` arrives at cycle 67.
- A second `start` while in DONE -> `done` drops next cycle, `err_cnt` clears, and the run repeats identically.
